// File: rtl/btn_mmio_if.sv
// ============================================================================
// Module   : btn_mmio_if
// Brief    : CPU data-memory bus bundle for the btn_mmio register window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btn_mmio_if;
    logic        enabler;
    logic        write_enabler;
    logic [31:0] addr;
    logic [3:0]  select;
    logic [31:0] data_input;
    logic [31:0] data_output;

    modport master (
        output enabler, write_enabler, addr, select, data_input,
        input  data_output
    );

    modport slave (
        input  enabler, write_enabler, addr, select, data_input,
        output data_output
    );
endinterface

`default_nettype wire

// File: rtl/btn_mmio.sv
// ============================================================================
// Module   : btn_mmio
// Brief    : Five debounced push-buttons with sticky press flags, press
//            counter and maskable level interrupt behind a 16-byte window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_mmio #(
    parameter logic [31:0] BASE            = 32'h0000_1000,
    parameter int          DEBOUNCE_CYCLES = 20000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    btn_mmio_if.slave       bus,
    input  wire logic [4:0] btn,
    output logic            irq
);

    localparam logic [15:0] c_cnt_last = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]  c_off_status = 2'd0;
    localparam logic [1:0]  c_off_edge   = 2'd1;
    localparam logic [1:0]  c_off_mask   = 2'd2;
    localparam logic [1:0]  c_off_count  = 2'd3;

    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    logic [4:0]  r_edge;
    logic [4:0]  r_mask;
    logic [15:0] r_count;

    logic [4:0]  w_stable;
    logic [4:0]  w_rise;
    logic [2:0]  w_npress;
    logic        w_hit;
    logic        w_wr;
    logic [1:0]  w_off;
    logic [4:0]  w_w1c;
    logic        w_unused_bits;

    assign w_hit = bus.enabler && (bus.addr[31:4] == BASE[31:4]);
    assign w_wr  = w_hit && bus.write_enabler;
    assign w_off = bus.addr[3:2];
    assign w_unused_bits = ^{bus.addr[1:0], bus.data_input[31:5]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic [15:0] r_cnt;
        logic        r_stable;

        // Counter runs only while the synchronized level disagrees with the accepted one.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (r_sync2[i] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt    <= '0;
                r_stable <= r_sync2[i];
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign w_stable[i] = r_stable;
        assign w_rise[i]   = r_sync2[i] && !r_stable && (r_cnt == c_cnt_last);
    end

    always_comb begin
        w_npress = '0;
        for (int k = 0; k < 5; k++) begin
            w_npress = w_npress + {2'b00, w_rise[k]};
        end
    end

    assign w_w1c = (w_wr && (w_off == c_off_edge) && bus.select[0])
                   ? bus.data_input[4:0] : 5'd0;

    // Press events are OR-ed in after the W1C so a coincident set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge  <= '0;
            r_mask  <= '0;
            r_count <= '0;
        end else begin
            r_edge <= (r_edge & ~w_w1c) | w_rise;
            if (w_wr && (w_off == c_off_mask) && bus.select[0]) begin
                r_mask <= bus.data_input[4:0];
            end
            if (w_wr && (w_off == c_off_count) && (bus.select[0] || bus.select[1])) begin
                r_count <= {13'd0, w_npress};
            end else begin
                r_count <= r_count + {13'd0, w_npress};
            end
        end
    end

    always_comb begin
        bus.data_output = 32'h0;
        if (w_hit && !bus.write_enabler) begin
            case (w_off)
                c_off_status: bus.data_output = {27'd0, w_stable};
                c_off_edge:   bus.data_output = {27'd0, r_edge};
                c_off_mask:   bus.data_output = {27'd0, r_mask};
                c_off_count:  bus.data_output = {16'd0, r_count};
                default:      bus.data_output = 32'h0;
            endcase
        end
    end

    assign irq = |(r_edge & r_mask);

endmodule

`default_nettype wire

// File: tb/tb_btn_mmio.sv
// ============================================================================
// Module   : tb_btn_mmio
// Brief    : Directed self-checking bench for btn_mmio (DEBOUNCE_CYCLES=4),
//            plus a DEBOUNCE_CYCLES=2 instance for the counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_mmio;

    logic       clk;
    logic       rst;
    logic [4:0] btn;
    logic [4:0] btn2;
    logic       irq;
    logic       irq2;

    btn_mmio_if bus ();
    btn_mmio_if bus2 ();

    btn_mmio #(.BASE(32'h0000_1000), .DEBOUNCE_CYCLES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .btn (btn),
        .irq (irq)
    );

    btn_mmio #(.BASE(32'h0000_1000), .DEBOUNCE_CYCLES(2)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave),
        .btn (btn2),
        .irq (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_irq;
        string       name;
    } vec_t;

    vec_t vecs [19];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.enabler = 1'b0; bus.write_enabler = 1'b0; bus.addr = '0;
        bus.select = '0; bus.data_input = '0;
        bus2.enabler = 1'b0; bus2.write_enabler = 1'b0; bus2.addr = '0;
        bus2.select = '0; bus2.data_input = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bus.enabler = 1'b1; bus.write_enabler = 1'b1; bus.addr = a;
        bus.select = s; bus.data_input = d;
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.enabler = 1'b1; bus.write_enabler = 1'b0; bus.addr = a;
        bus.select = 4'b0000;
        #1;
        d = bus.data_output;
        bus_idle();
        #1;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic read2_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus2.enabler = 1'b1; bus2.write_enabler = 1'b0; bus2.addr = a;
        #1;
        check(name, bus2.data_output, exp);
        bus_idle();
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].sel, vecs[i].wdata);
            end else begin
                read_check(vecs[i].name, vecs[i].addr, vecs[i].exp_rd);
                check({vecs[i].name, "_irq"}, {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            end
        end
    endtask

    task automatic press2(input logic [4:0] pattern);
        btn2 = pattern;
        repeat (2) tick();
        btn2 = 5'd0;
        repeat (2) tick();
    endtask

    initial begin
        vecs[0]  = '{0, 32'h1000, 4'h0, 32'h0, 32'h0, 0, "rst_status"};
        vecs[1]  = '{0, 32'h1004, 4'h0, 32'h0, 32'h0, 0, "rst_edge"};
        vecs[2]  = '{0, 32'h1008, 4'h0, 32'h0, 32'h0, 0, "rst_mask"};
        vecs[3]  = '{0, 32'h100C, 4'h0, 32'h0, 32'h0, 0, "rst_count"};
        vecs[4]  = '{0, 32'h1003, 4'h0, 32'h0, 32'h0, 0, "rst_status_unaligned"};
        vecs[5]  = '{1, 32'h1008, 4'h1, 32'h1, 32'h0, 0, ""};
        vecs[6]  = '{0, 32'h1008, 4'h0, 32'h0, 32'h1, 1, "mask_set"};
        vecs[7]  = '{1, 32'h1004, 4'h1, 32'h1, 32'h0, 0, ""};
        vecs[8]  = '{0, 32'h1004, 4'h0, 32'h0, 32'h0, 0, "edge_w1c"};
        vecs[9]  = '{1, 32'h1004, 4'h2, 32'h1, 32'h0, 0, ""};
        vecs[10] = '{0, 32'h1004, 4'h0, 32'h0, 32'h1, 1, "edge_w1c_wrong_lane"};
        vecs[11] = '{1, 32'h1000, 4'hF, 32'h1F, 32'h0, 0, ""};
        vecs[12] = '{0, 32'h1000, 4'h0, 32'h0, 32'h1, 1, "status_ro"};
        vecs[13] = '{1, 32'h1008, 4'hE, 32'h0, 32'h0, 0, ""};
        vecs[14] = '{0, 32'h100B, 4'h0, 32'h0, 32'h1, 1, "mask_wrong_lane"};
        vecs[15] = '{0, 32'h100C, 4'h0, 32'h0, 32'h2, 1, "count_two_presses"};
        vecs[16] = '{1, 32'h2008, 4'hF, 32'h0, 32'h0, 0, ""};
        vecs[17] = '{0, 32'h2008, 4'h0, 32'h0, 32'h0, 1, "miss_read"};
        vecs[18] = '{0, 32'h1008, 4'h0, 32'h0, 32'h1, 1, "miss_write_ignored"};

        rst = 1'b1; btn = '0; btn2 = '0;
        bus_idle();
        repeat (2) tick();
        read_check("in_reset_status", 32'h1000, 32'h0);
        rst = 1'b0;
        run_vecs(0, 4);

        // Single press: accepted exactly 2 + 4 cycles after the level change.
        btn = 5'b00001;
        repeat (5) tick();
        read_check("status_before_debounce", 32'h1000, 32'h0);
        tick();
        read_check("status_after_debounce", 32'h1000, 32'h1);
        read_check("edge_after_press", 32'h1004, 32'h1);
        read_check("count_after_press", 32'h100C, 32'h1);

        btn = 5'b00011;
        repeat (2) tick();
        btn = 5'b00001;
        repeat (8) tick();
        read_check("glitch_status", 32'h1000, 32'h1);
        read_check("glitch_count", 32'h100C, 32'h1);

        run_vecs(5, 8);
        btn = 5'b00000;
        repeat (10) tick();
        btn = 5'b00001;
        repeat (10) tick();
        run_vecs(9, 18);

        // All five pressed together land in the same cycle.
        bus_write(32'h100C, 4'b0001, 32'h0);
        bus_write(32'h1004, 4'b0001, 32'h1F);
        btn = 5'b00000;
        repeat (10) tick();
        read_check("release_not_counted", 32'h100C, 32'h0);
        btn = 5'b11111;
        repeat (5) tick();
        read_check("count_before_burst", 32'h100C, 32'h0);
        tick();
        read_check("count_burst", 32'h100C, 32'h5);
        read_check("edge_burst", 32'h1004, 32'h1F);
        check("irq_burst", {31'd0, irq}, 32'h1);

        // W1C and press of the same bit in one cycle.
        btn = 5'b00000;
        repeat (10) tick();
        btn = 5'b00100;
        repeat (5) tick();
        bus_write(32'h1004, 4'b0001, 32'h05);
        read_check("edge_set_beats_w1c", 32'h1004, 32'h1E);
        read_check("status_bit2", 32'h1000, 32'h04);

        // COUNT clear coincident with two presses, via lane 1.
        btn = 5'b00011;
        repeat (5) tick();
        bus_write(32'h100C, 4'b0010, 32'hFFFF);
        read_check("count_clear_with_press", 32'h100C, 32'h2);
        bus_write(32'h100C, 4'b0100, 32'h0);
        read_check("count_clear_wrong_lane", 32'h100C, 32'h2);
        bus_write(32'h100C, 4'b0001, 32'h0);
        read_check("count_clear", 32'h100C, 32'h0);

        // Reset mid-debounce discards the partial count.
        btn = 5'b00000;
        repeat (10) tick();
        btn = 5'b00001;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("irq_in_reset", {31'd0, irq}, 32'h0);
        read_check("in_reset_count", 32'h100C, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        read_check("post_reset_status_early", 32'h1000, 32'h0);
        tick();
        read_check("post_reset_status", 32'h1000, 32'h1);
        read_check("miss_0x2000", 32'h2000, 32'h0);
        read_check("post_miss_status", 32'h1000, 32'h1);
        read_check("post_miss_count", 32'h100C, 32'h1);

        // Wrap: 13106 * 5 + 4 = 0xFFFE, then 3 more presses.
        for (int p = 0; p < 13106; p++) press2(5'b11111);
        press2(5'b01111);
        repeat (8) tick();
        read2_check("wrap_preload", 32'h100C, 32'hFFFE);
        press2(5'b00111);
        repeat (8) tick();
        read2_check("wrap_result", 32'h100C, 32'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
